// File: rtl/branch_unit.sv
// branch_unit
//   Resolves one instruction per Start request. A BR instruction (IR[15:12]
//   = 4'b0000) walks IDLE -> EVAL -> RESOLVE -> DONE. Any other instruction
//   walks IDLE -> DONE and touches neither LD_BEN nor LD_PC.
//
// Ports
//   Clk        system clock; all state updates on the rising edge
//   Reset      asynchronous active-high reset; clears all state immediately
//   Start      resolve request; only looked at in IDLE
//   IR         instruction word; latched when Start is accepted
//   PC_in      already-incremented PC; latched when Start is accepted
//   BEN        branch enable from the condition-code block (valid in RESOLVE)
//   LD_BEN     strobe to the condition-code block's BEN register (EVAL)
//   LD_PC      PC load strobe (RESOLVE and BEN=1)
//   PC_out     branch target while LD_PC=1, otherwise 16'h0000
//   Busy       high in every state except IDLE
//   Done       one-cycle completion pulse
//   Taken_cnt  saturating count of taken branches since reset
module branch_unit #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [15:0]      IR,
  input  logic [15:0]      PC_in,
  input  logic             BEN,
  output logic             LD_BEN,
  output logic             LD_PC,
  output logic [15:0]      PC_out,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Taken_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EVAL    = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [8:0]       off_reg;   // only the BR offset field is needed after acceptance
  logic [15:0]      pc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [15:0]      target;
  logic             accept;
  logic             is_br;

  // IR[11:9] (the n/z/p condition bits) are consumed by the condition-code
  // block, not here.
  logic unused_bits;
  assign unused_bits = ^IR[11:9];

  assign accept = (state_reg == IDLE) && Start;
  assign is_br  = (IR[15:12] == 4'b0000);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      off_reg   <= '0;
      pc_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        off_reg <= IR[8:0];
        pc_reg  <= PC_in;
      end
      // Count on the edge leaving RESOLVE with a taken branch; hold at all-ones.
      if ((state_reg == RESOLVE) && BEN && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = is_br ? EVAL : DONE;
      EVAL:    state_next = RESOLVE;
      RESOLVE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign-extended 9-bit offset; the 16-bit sum wraps silently.
  assign target = pc_reg + {{7{off_reg[8]}}, off_reg};

  always_comb begin
    LD_BEN = 1'b0;
    LD_PC  = 1'b0;
    PC_out = 16'h0000;
    Busy   = (state_reg != IDLE);
    Done   = 1'b0;
    case (state_reg)
      EVAL:    LD_BEN = 1'b1;
      RESOLVE: begin
        // BEN is the registered output of the condition-code block, loaded by
        // the LD_BEN strobe in EVAL, so it is stable for the whole cycle.
        LD_PC = BEN;
        if (BEN) PC_out = target;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign Taken_cnt = cnt_reg;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      ir = 16'h0000;
  logic [15:0]      pc_in = 16'h0000;
  logic             ben = 1'b0;
  logic             ld_ben, ld_pc, busy, done;
  logic [15:0]      pc_out;
  logic [CNT_W-1:0] taken_cnt;

  int tests = 0;
  int fails = 0;

  branch_unit #(.CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .IR(ir), .PC_in(pc_in), .BEN(ben),
    .LD_BEN(ld_ben), .LD_PC(ld_pc), .PC_out(pc_out), .Busy(busy), .Done(done),
    .Taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // An accepted request expands into the list of per-cycle phases it must
  // produce; the model just plays that list back, one entry per clock.
  localparam int K_IDLE = 0, K_EVAL = 1, K_RES = 2, K_DONE = 3;
  typedef struct {
    int          kind;
    logic [15:0] tgt;
  } phase_t;

  phase_t q[$];
  phase_t cur;
  int     taken_m;

  function automatic logic [15:0] br_target(input logic [15:0] i, input logic [15:0] p);
    int off;
    off = (i[8] == 1'b1) ? int'(i[8:0]) - 512 : int'(i[8:0]);
    return 16'((int'(p) + off) % 65536 + 65536);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cur.kind = K_IDLE;
      cur.tgt  = 16'h0000;
      taken_m  = 0;
    end else begin
      if (cur.kind == K_RES && ben) taken_m = (taken_m < CNT_MAX) ? taken_m + 1 : CNT_MAX;
      if (cur.kind == K_IDLE && start) begin
        if (ir[15:12] == 4'b0000) begin
          q.push_back('{K_EVAL, 16'h0000});
          q.push_back('{K_RES, br_target(ir, pc_in)});
        end
        q.push_back('{K_DONE, 16'h0000});
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{K_IDLE, 16'h0000};
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_ldpc;
    exp_ldpc = (cur.kind == K_RES) && ben;
    check("busy",    busy,      cur.kind != K_IDLE);
    check("ld_ben",  ld_ben,    cur.kind == K_EVAL);
    check("ld_pc",   ld_pc,     exp_ldpc);
    check("pc_out",  pc_out,    exp_ldpc ? cur.tgt : 16'h0000);
    check("done",    done,      cur.kind == K_DONE);
    check("taken",   taken_cnt, taken_m);
    check("excl",    ((32'(ld_ben) + 32'(ld_pc) + 32'(done)) <= 1), 1);
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic run_op(input string nm, input logic [15:0] i, input logic [15:0] p,
                        input logic b, input int exp_lat, input logic exp_ldpc,
                        input logic [15:0] exp_pc, input int exp_cnt);
    logic seen_ben, seen_pc;
    logic [15:0] pcv;
    int lat, cntv;
    seen_ben = 0; seen_pc = 0; pcv = 16'h0000; lat = 0; cntv = -1;
    @(posedge clk); #2;
    start = 1'b1; ir = i; pc_in = p; ben = b;
    @(posedge clk); #2;
    // Scramble the request inputs after acceptance; they must have no effect.
    start = 1'b0; ir = 16'hDEAD; pc_in = 16'hBEEF;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (ld_ben) seen_ben = 1'b1;
      if (ld_pc) begin seen_pc = 1'b1; pcv = pc_out; end
      if (done) begin lat = c; cntv = int'(taken_cnt); end
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_ldben"},   seen_ben, exp_lat == 3);
    check({nm, "_ldpc"},    seen_pc, exp_ldpc);
    check({nm, "_target"},  pcv, exp_pc);
    check({nm, "_count"},   cntv, exp_cnt);
    $display("[TB] op %s IR=%h PC=%h BEN=%0d: latency=%0d ld_pc=%0d pc_out=%h cnt=%0d",
             nm, i, p, b, lat, seen_pc, pcv, cntv);
  endtask

  initial begin
    int dones, idles;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ldben", ld_ben, 0);
    check("rst_ldpc", ld_pc, 0);
    check("rst_pcout", pc_out, 16'h0000);
    check("rst_done", done, 0);
    check("rst_cnt", taken_cnt, 0);
    $display("[TB] reset state checked");
    @(posedge clk); #2 rst = 1'b0;

    run_op("taken",    16'h0E05, 16'h3001, 1'b1, 3, 1'b1, 16'h3006, 1);
    run_op("nottaken", 16'h0405, 16'h3001, 1'b0, 3, 1'b0, 16'h0000, 1);
    run_op("negwrap",  16'h0FFE, 16'h0001, 1'b1, 3, 1'b1, 16'hFFFF, 2);
    run_op("nonbr",    16'h1021, 16'h3001, 1'b1, 1, 1'b0, 16'h0000, 2);
    run_op("poswrap",  16'h0E01, 16'hFFFF, 1'b1, 3, 1'b1, 16'h0000, 3);

    // Asynchronous reset in the middle of RESOLVE.
    @(posedge clk); #2;
    start = 1'b1; ir = 16'h0E05; pc_in = 16'h3001; ben = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_ldpc", ld_pc, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_ldpc", ld_pc, 0);
    check("midrst_pcout", pc_out, 16'h0000);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", taken_cnt, 0);
    $display("[TB] op reset-in-RESOLVE: ld_pc=%0d busy=%0d cnt=%0d", ld_pc, busy, taken_cnt);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_op("afterrst", 16'h0E05, 16'h3001, 1'b1, 3, 1'b1, 16'h3006, 1);

    // Start held high: one operation per four cycles, counter saturates.
    @(posedge clk); #2;
    start = 1'b1; ir = 16'h0E05; pc_in = 16'h3001; ben = 1'b1;
    dones = 0; idles = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(done);
      idles += int'(!busy);
    end
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    check("held_dones", dones, 5);
    check("held_idles", idles, 5);
    check("sat_cnt", taken_cnt, 3);
    $display("[TB] op held-start: dones=%0d idle_cycles=%0d cnt=%0d", dones, idles, taken_cnt);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
